rr_arbiter_16: RTL and testbench
================================

RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8: maximum cycles one grant is held before forced rotation; 0 disables the limit.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 16: request vector, bit i = requester i.
REQ-005 SHALL have port release, input, 1: pulse from the current owner ending its grant.
REQ-006 SHALL have port gnt, output, 16: one-hot grant vector, all-zero when no grant.
REQ-007 SHALL have port gnt_idx, output, 4: binary index of the current owner; 0 when gnt_valid=0.
REQ-008 SHALL have port gnt_valid, output, 1: high while a grant is held.

Function
REQ-009 SHALL implement FSM states IDLE and GRANT, and SHALL hold a 4-bit round-robin pointer ptr.
REQ-010 In IDLE with req!=0, SHALL select the first set req bit searching upward from ptr, wrapping 15->0, then enter GRANT at the next edge with gnt_idx=selected index.
REQ-011 In IDLE with req==0, SHALL remain in IDLE; gnt=0, gnt_valid=0.
REQ-012 Latency SHALL be one cycle: a req sampled in IDLE at edge N yields gnt_valid=1 after edge N.
REQ-013 gnt SHALL equal the one-hot decode of gnt_idx when gnt_valid=1, and 16'h0000 otherwise; at most one gnt bit high in any cycle.
REQ-014 In GRANT, the grant SHALL end at an edge where any of these holds: release=1; req[gnt_idx]=0; HOLD_MAX!=0 and hold count = HOLD_MAX-1.
REQ-015 On grant end, SHALL set ptr=gnt_idx+1 (mod 16, 15 wraps to 0) and return to IDLE; gnt_valid=0 for at least one cycle between consecutive grants.
REQ-016 The hold counter SHALL clear on entry to GRANT, increment each GRANT cycle, and saturate rather than wrap.
REQ-017 release asserted while in IDLE SHALL be ignored.
REQ-018 Requests arriving or dropping in the same cycle as grant end SHALL be evaluated in the following IDLE cycle against the updated ptr.
REQ-019 A requester still asserting req after a forced (HOLD_MAX) end SHALL be re-granted only after the round-robin search passes it again.

Reset
REQ-020 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, ptr=0, hold count=0, gnt_idx=0, gnt=0, gnt_valid=0.
REQ-021 Reset asserted mid-grant SHALL drop the grant with no release required; the first arbitration after deassertion SHALL start from ptr=0.
REQ-022 rst_n deassertion SHALL take effect at the first clk edge after it.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding (IDLE=0, GRANT=1), NUM_REQ=16 and IDX_W=4.
REQ-024 The index-to-one-hot conversion SHALL use one instance of the existing decoder_4to16, with its output gated by gnt_valid.
REQ-025 The priority search SHALL be local combinational logic; no other sub-modules.

Verification
REQ-026 Reset: rst_n=0 mid-grant of idx 5 -> gnt=0, gnt_valid=0 the same cycle; after release, req=16'h0021 -> grant idx 0.
REQ-027 Round robin: req=16'hFFFF held, release pulsed in each GRANT cycle -> grant order 0,1,2,...,15,0 with one IDLE cycle between grants.
REQ-028 Wrap: ptr=15, req=16'h8001 -> grant 15; after release -> grant 0.
REQ-029 Timeout: HOLD_MAX=8, req=16'h0003, no release -> idx 0 held exactly 8 cycles, then idx 1.
REQ-030 Drop: granted idx 3 deasserts req[3] -> gnt_valid=0 next cycle, ptr=4; release pulse in IDLE -> no effect.
REQ-031 Invariant (all tests): popcount(gnt)<=1, and gnt==decode(gnt_idx) whenever gnt_valid=1.

Source files
------------

// File: rtl/rr_arbiter_16_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter_16_pkg
// Shared definitions for the 16-way round-robin arbiter:
//   - FSM state encoding (IDLE=0, GRANT=1)
//   - requester count and index width
//   - rr_pick(): round-robin priority search helper
// ----------------------------------------------------------------------------
package rr_arbiter_16_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Returns the first set bit of req found searching upward from ptr,
    // wrapping 15 -> 0. The caller only uses the result when req != 0.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Index arithmetic is modulo 16 by virtue of the 4-bit width.
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

endpackage : rr_arbiter_16_pkg

// File: rtl/decoder_4to16.sv
// ----------------------------------------------------------------------------
// decoder_4to16
// Binary index to one-hot decoder.
// Ports:
//   idx    - 4-bit binary index
//   onehot - 16-bit one-hot vector, bit idx set
// ----------------------------------------------------------------------------
module decoder_4to16 (
    input  logic [3:0]  idx,
    output logic [15:0] onehot
);

    // Pure combinational decode of the index.
    always_comb begin
        onehot = 16'h0000;
        onehot = 16'h0001 << idx;
    end

endmodule : decoder_4to16

// File: rtl/rr_arbiter_16.sv
// ----------------------------------------------------------------------------
// rr_arbiter_16
// 16-requester round-robin arbiter with a two-state FSM (IDLE/GRANT).
// A request seen in IDLE is granted at the next edge; the grant lasts until
// the owner releases it, drops its request, or (HOLD_MAX != 0) it has been
// held HOLD_MAX cycles. The pointer then moves past the owner so the search
// restarts from the next requester. IDLE is always visited between grants.
//
// Parameters:
//   HOLD_MAX    - max cycles a grant is held before forced rotation (0 = no limit)
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   req         - request vector, bit i = requester i
//   gnt_release - pulse from the current owner ending its grant
//                 ("release" is a reserved word in SystemVerilog)
//   gnt         - one-hot grant vector, all-zero when no grant
//   gnt_idx     - binary index of current owner, 0 when gnt_valid = 0
//   gnt_valid   - high while a grant is held
// ----------------------------------------------------------------------------
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               gnt_release,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    // Counter only has to reach HOLD_MAX-1; keep at least one bit.
    localparam int               CNT_W     = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam bit               HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1)
                                                            : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    arb_state_e             state_r;
    logic [IDX_W-1:0]       ptr_r;
    logic [IDX_W-1:0]       idx_r;
    logic                   valid_r;
    logic [CNT_W-1:0]       hold_cnt_r;

    logic [IDX_W-1:0]       pick_s;
    logic                   any_req_s;
    logic                   grant_end_s;
    logic [NUM_REQ-1:0]     dec_s;

    // Round-robin search and grant-termination conditions.
    always_comb begin
        pick_s      = rr_pick(req, ptr_r);
        any_req_s   = (req != 16'h0000);
        grant_end_s = 1'b0;
        if (state_r == GRANT) begin
            grant_end_s = gnt_release
                        || !req[idx_r]
                        || (HOLD_EN && (hold_cnt_r == HOLD_LAST));
        end else begin
            grant_end_s = 1'b0;
        end
    end

    // Arbitration FSM with registered index/valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= 4'd0;
            idx_r      <= 4'd0;
            valid_r    <= 1'b0;
            hold_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // gnt_release is deliberately not looked at here.
                    if (any_req_s) begin
                        state_r    <= GRANT;
                        idx_r      <= pick_s;
                        valid_r    <= 1'b1;
                        hold_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        state_r    <= IDLE;
                        idx_r      <= 4'd0;
                        valid_r    <= 1'b0;
                    end
                end
                GRANT: begin
                    if (grant_end_s) begin
                        state_r    <= IDLE;
                        ptr_r      <= idx_r + 4'd1;
                        idx_r      <= 4'd0;
                        valid_r    <= 1'b0;
                        hold_cnt_r <= {CNT_W{1'b0}};
                    end else if (hold_cnt_r != CNT_SAT) begin
                        hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    idx_r      <= 4'd0;
                    valid_r    <= 1'b0;
                    hold_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    decoder_4to16 u_dec (
        .idx    (idx_r),
        .onehot (dec_s)
    );

    // Decoder output is masked so no bit can be high without a valid grant.
    assign gnt       = dec_s & {NUM_REQ{valid_r}};
    assign gnt_idx   = idx_r;
    assign gnt_valid = valid_r;

endmodule : rr_arbiter_16

// File: tb/tb_rr_arbiter_16.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_16
// Directed self-checking bench for rr_arbiter_16 (HOLD_MAX = 8).
// Inputs change 1 time unit after the rising edge; outputs are checked there
// and continuously on the falling edge for the one-hot invariant.
// ----------------------------------------------------------------------------
module tb_rr_arbiter_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        gnt_release;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;

    int checks_cnt;
    int errors_cnt;

    rr_arbiter_16 #(.HOLD_MAX(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .gnt_release (gnt_release),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] idx);
        logic [15:0] oh;
        oh = 16'h0001 << idx;
        check({tag, "_valid"}, {31'd0, gnt_valid}, 32'd1);
        check({tag, "_idx"},   {28'd0, gnt_idx},   {28'd0, idx});
        check({tag, "_gnt"},   {16'd0, gnt},       {16'd0, oh});
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, {31'd0, gnt_valid}, 32'd0);
        check({tag, "_idx"},   {28'd0, gnt_idx},   32'd0);
        check({tag, "_gnt"},   {16'd0, gnt},       32'd0);
    endtask

    // Invariant: at most one grant bit, and gnt matches gnt_idx when valid.
    always @(negedge clk) begin
        logic [15:0] oh;
        oh = 16'h0001 << gnt_idx;
        check("inv_onehot", {31'd0, ($countones(gnt) <= 1)}, 32'd1);
        if (gnt_valid) begin
            check("inv_decode", {16'd0, gnt}, {16'd0, oh});
        end else begin
            check("inv_zero", {16'd0, gnt}, 32'd0);
        end
    end

    initial begin
        checks_cnt  = 0;
        errors_cnt  = 0;
        rst_n       = 1'b0;
        req         = 16'h0000;
        gnt_release = 1'b0;
        tick();
        tick();
        expect_idle("reset");
        rst_n = 1'b1;

        // Reset mid-grant of requester 5.
        req = 16'h0020;
        tick();
        expect_grant("rst_pre", 4'd5);
        #2 rst_n = 1'b0;
        #1;
        expect_idle("rst_async");
        req = 16'h0000;
        tick();
        rst_n = 1'b1;
        req   = 16'h0021;
        tick();
        expect_grant("rst_after", 4'd0);
        gnt_release = 1'b1;
        tick();
        gnt_release = 1'b0;
        req         = 16'h0000;
        expect_idle("rst_rel");

        // Round robin from ptr=0 with everyone requesting.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            tick();
            expect_grant($sformatf("rr%0d", k), 4'(k % 16));
            gnt_release = 1'b1;
            tick();
            gnt_release = 1'b0;
            expect_idle($sformatf("rr_gap%0d", k));
        end
        req = 16'h0000;
        tick();

        // Wrap: move ptr to 15 via a grant to 14, then 15 -> 0.
        req = 16'h4000;
        tick();
        expect_grant("wrap_setup", 4'd14);
        gnt_release = 1'b1;
        req         = 16'h8001;
        tick();
        gnt_release = 1'b0;
        expect_idle("wrap_gap0");
        tick();
        expect_grant("wrap15", 4'd15);
        gnt_release = 1'b1;
        tick();
        gnt_release = 1'b0;
        expect_idle("wrap_gap1");
        tick();
        expect_grant("wrap0", 4'd0);
        gnt_release = 1'b1;
        req         = 16'h0000;
        tick();
        gnt_release = 1'b0;

        // Timeout: requester 0 held exactly 8 cycles, then requester 1.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req = 16'h0003;
        for (int c = 1; c <= 8; c++) begin
            tick();
            expect_grant($sformatf("hold%0d", c), 4'd0);
        end
        tick();
        expect_idle("hold_end");
        tick();
        expect_grant("hold_next", 4'd1);
        gnt_release = 1'b1;
        req         = 16'h0000;
        tick();
        gnt_release = 1'b0;

        // Drop: requester 3 lets go, ptr moves to 4; release in IDLE ignored.
        req = 16'h0008;
        tick();
        expect_grant("drop_gnt", 4'd3);
        req = 16'h0000;
        tick();
        expect_idle("drop_end");
        gnt_release = 1'b1;
        tick();
        gnt_release = 1'b0;
        expect_idle("idle_rel");
        req = 16'h0018;
        tick();
        expect_grant("drop_ptr", 4'd4);
        gnt_release = 1'b1;
        req         = 16'h0000;
        tick();
        gnt_release = 1'b0;
        expect_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_rr_arbiter_16
